// File: rtl/vitdec_pkg.sv
// Shared types, default parameters and trellis helper for the register-exchange Viterbi decoder.
package vitdec_pkg;

  localparam int         K_DEF   = 3;
  localparam logic [2:0] G0_DEF  = 3'o7;
  localparam logic [2:0] G1_DEF  = 3'o5;
  localparam int         SW_DEF  = 3;
  localparam int         TB_DEF  = 16;
  localparam int         PMW_DEF = 8;

  typedef logic [PMW_DEF-1:0] metric_t;
  typedef logic               dec_t;

  // Encoder register is {input, state}: the newest bit sits under the generator MSB.
  function automatic logic exp_bit(input int unsigned state, input logic u,
                                   input int unsigned g, input int unsigned k);
    logic [31:0] sr;
    sr = (32'(u) << (k - 1)) | state;
    return ^(sr & g);
  endfunction

endpackage

// File: rtl/vitdec_acs.sv
// One trellis state: add branch metrics, pick the cheaper valid predecessor, clear MSB on normalise.
module vitdec_acs
  import vitdec_pkg::*;
#(
  parameter int PMW = PMW_DEF,
  parameter int SW  = SW_DEF
) (
  input  logic [PMW-1:0] m0,
  input  logic [PMW-1:0] m1,
  input  logic           v0,
  input  logic           v1,
  input  logic [SW:0]    bm0,
  input  logic [SW:0]    bm1,
  input  logic           norm,
  output logic [PMW-1:0] metric,
  output logic           valid,
  output dec_t           dec
);

  logic [PMW-1:0] c0;
  logic [PMW-1:0] c1;

  function automatic logic [PMW-1:0] norm_clr(input logic [PMW-1:0] m, input logic en);
    return en ? {1'b0, m[PMW-2:0]} : m;
  endfunction

  assign c0 = norm_clr(m0, norm) + PMW'(bm0);
  assign c1 = norm_clr(m1, norm) + PMW'(bm1);

  // Ties go to the even predecessor; an invalid predecessor never wins.
  assign dec    = v1 && (!v0 || (c1 < c0));
  assign valid  = v0 || v1;
  assign metric = !valid ? '0 : (dec ? c1 : c0);

endmodule

// File: rtl/vitdec_param.sv
// Parameterised soft-decision Viterbi decoder, register-exchange survivors, one-deep output register.
// Define VITDEC_BEST_STATE_EN to decode from the minimum-metric state instead of state 0.
module vitdec_param
  import vitdec_pkg::*;
#(
  parameter int           K   = K_DEF,
  parameter logic [K-1:0] G0  = G0_DEF,
  parameter logic [K-1:0] G1  = G1_DEF,
  parameter int           SW  = SW_DEF,
  parameter int           TB  = TB_DEF,
  parameter int           PMW = PMW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*SW-1:0] d_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          d_out
);

  localparam int NS = 1 << (K - 1);
  localparam int CW = $clog2(TB + 1);

  function automatic logic [SW:0] branch_metric(input logic [2*SW-1:0] d,
                                                input logic e0, input logic e1);
    logic [SW-1:0] a0;
    logic [SW-1:0] a1;
    a0 = e0 ? ~d[SW-1:0] : d[SW-1:0];
    a1 = e1 ? ~d[2*SW-1:SW] : d[2*SW-1:SW];
    return {1'b0, a0} + {1'b0, a1};
  endfunction

  function automatic logic [CW-1:0] cnt_sat(input logic [CW-1:0] c);
    return (c == CW'(TB)) ? c : c + CW'(1);
  endfunction

  logic [PMW-1:0] metric_q [NS];
  logic [PMW-1:0] metric_d [NS];
  logic [PMW-1:0] pred_m   [NS];
  logic [TB-1:0]  surv_q   [NS];
  logic [TB-1:0]  surv_d   [NS];
  logic [NS-1:0]  valid_q, valid_d, pred_v, dec_d, msb;
  logic [CW-1:0]  cnt_q;
  logic           xfer, restart, norm, fire, out_bit;

  assign in_ready = out_ready || !out_valid;
  assign xfer     = in_valid && in_ready;
  assign restart  = start && xfer;
  assign fire     = !restart && (cnt_q == CW'(TB));

  // A restart feeds the ACS array a fresh trellis instead of the stored one.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pred_m[i] = restart ? '0 : metric_q[i];
      msb[i]    = metric_q[i][PMW-1];
    end
    pred_v = restart ? NS'(1) : valid_q;
  end

  assign norm = !restart && ((~pred_v | msb) == '1);

  for (genvar s = 0; s < NS; s++) begin : g_state
    localparam int P0 = (2 * s) % NS;
    localparam int P1 = P0 + 1;
    localparam bit U  = (s >= NS / 2);
    logic [SW:0] bm0;
    logic [SW:0] bm1;

    assign bm0 = branch_metric(d_in, exp_bit(P0, U, 32'(G0), K), exp_bit(P0, U, 32'(G1), K));
    assign bm1 = branch_metric(d_in, exp_bit(P1, U, 32'(G0), K), exp_bit(P1, U, 32'(G1), K));

    vitdec_acs #(.PMW(PMW), .SW(SW)) u_acs (
      .m0     (pred_m[P0]),
      .m1     (pred_m[P1]),
      .v0     (pred_v[P0]),
      .v1     (pred_v[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .norm   (norm),
      .metric (metric_d[s]),
      .valid  (valid_d[s]),
      .dec    (dec_d[s])
    );

    assign surv_d[s] = {(dec_d[s] ? surv_q[P1][TB-2:0] : surv_q[P0][TB-2:0]), U};
  end

`ifdef VITDEC_BEST_STATE_EN
  logic [K-2:0]   best_idx;
  logic [PMW-1:0] best_m;
  logic           best_found;

  always_comb begin
    best_idx   = '0;
    best_m     = '1;
    best_found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (valid_q[i] && (!best_found || (metric_q[i] < best_m))) begin
        best_idx   = (K-1)'(i);
        best_m     = metric_q[i];
        best_found = 1'b1;
      end
    end
  end

  assign out_bit = surv_q[best_idx][TB-1];
`else
  assign out_bit = surv_q[0][TB-1];
`endif

  // Trellis state and output register advance together on each symbol transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        metric_q[i] <= '0;
        surv_q[i]   <= '0;
      end
      valid_q   <= NS'(1);
      cnt_q     <= '0;
      out_valid <= 1'b0;
      d_out     <= 1'b0;
    end else if (xfer) begin
      for (int i = 0; i < NS; i++) begin
        metric_q[i] <= metric_d[i];
        surv_q[i]   <= surv_d[i];
      end
      valid_q   <= valid_d;
      cnt_q     <= restart ? CW'(1) : cnt_sat(cnt_q);
      out_valid <= fire;
      if (fire) d_out <= out_bit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
